edge_fifo_reader: RTL and testbench

EDGE_FIFO_READER -- requirements
Module: edge_fifo_reader

---
 rtl/edge_fifo_reader.sv | 259 +++++++++++++++++++++++++
 tb/tb_edge_fifo_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_fifo_reader.sv
// -----------------------------------------------------------------------------
// edge_fifo_reader
//
// Pulls graph edges {src, dst, weight} out of an upstream FIFO with one cycle
// of read latency and presents them one at a time on a valid/ready output.
// A partition starts with a one-cycle start pulse. It ends when a word whose
// src field equals SENTINEL is read; that word is consumed, not forwarded.
//
// A 2-entry output buffer decouples the FIFO read latency from downstream
// back-pressure. Each buffer entry has a held bit. Words that arrive after
// the sentinel, because their read was already in flight, are kept as held
// entries. They are not shown downstream until the next accepted start
// releases them, so they become the first edges of the next partition.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle pulse beginning a partition (honoured only in IDLE)
//   fifo_empty  upstream FIFO empty flag
//   fifo_re     upstream FIFO read enable (combinational)
//   fifo_dout   upstream FIFO read data, valid the cycle after fifo_re
//   out_valid   an edge is presented on out_src/out_dst/out_weight
//   out_ready   downstream accepts the presented edge
//   out_src     src field of the head edge
//   out_dst     dst field of the head edge
//   out_weight  weight field of the head edge
//   busy        high while in RUN or FLUSH
//   done        one-cycle pulse at end of partition
//   edge_count  edges handed off in the current or most recent partition
// -----------------------------------------------------------------------------
module edge_fifo_reader #(
  parameter int unsigned        FIFO_WIDTH = 32'd96,
  parameter int unsigned        FIELD_W    = 32'd32,
  parameter logic [FIELD_W-1:0] SENTINEL   = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIELD_W-1:0]    out_src,
  output logic [FIELD_W-1:0]    out_dst,
  output logic [FIELD_W-1:0]    out_weight,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           edge_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_r;
  state_t                state_s;

  logic [FIFO_WIDTH-1:0] buf_r [2];     // output buffer storage
  logic [1:0]            held_r;        // per-entry held bit
  logic [1:0]            held_s;
  logic                  head_r;        // index of the oldest entry
  logic [1:0]            occ_r;         // number of occupied entries (0..2)
  logic [1:0]            occ_s;
  logic                  inflight_r;    // fifo_dout carries a word this cycle
  logic [31:0]           edge_count_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [FIELD_W-1:0]    cap_src_s;
  logic                  cap_sentinel_s;
  logic                  start_ok_s;
  logic                  drop_s;        // sentinel consumed in RUN, not stored
  logic                  store_s;       // captured word goes into the buffer
  logic                  tail_s;        // free slot written by a capture
  logic                  pop_s;
  logic [2:0]            credit_s;
  logic                  unheld_left_s;
  logic                  flush_done_s;
  logic [FIFO_WIDTH-1:0] head_word_s;
  logic                  out_valid_s;
  logic                  fifo_re_s;
  logic                  busy_s;
  logic                  done_s;

  // True when slot idx holds an entry that can still be released downstream
  // once this cycle's pop is taken into account.
  function automatic logic slot_unheld_left(
    input logic [1:0] occ,
    input logic       head,
    input logic       idx,
    input logic       held,
    input logic       pop
  );
    logic live;
    live = (occ == 2'd2) || ((occ == 2'd1) && (head == idx));
    return live && !held && !(pop && (head == idx));
  endfunction

  // Classify the word arriving on fifo_dout and find where it is written.
  always_comb begin
    cap_src_s      = fifo_dout[FIFO_WIDTH-1 -: FIELD_W];
    cap_sentinel_s = (cap_src_s == SENTINEL);
    start_ok_s     = (state_r == ST_IDLE) && start;
    // Only a sentinel seen while running ends the partition. A sentinel that
    // arrives later is treated as ordinary (held) data.
    drop_s         = inflight_r && cap_sentinel_s && (state_r == ST_RUN);
    store_s        = inflight_r && !drop_s && !rst;
    // The read credit keeps occ at 1 or less whenever a capture lands, so
    // head + occ always names a free slot here.
    tail_s         = head_r ^ occ_r[0];
  end

  // FSM outputs and the handshake terms derived from the registered state.
  always_comb begin
    head_word_s = buf_r[head_r];
    out_valid_s = !rst && (occ_r != 2'd0) && !held_r[head_r];
    pop_s       = out_valid_s && out_ready;
    // Entries that would be occupied after this cycle if a new read were
    // issued now: current entries, plus the one in flight, minus the one
    // leaving.
    credit_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // fifo_empty gating is mandatory: the upstream FIFO is not safe against
    // a read at empty.
    fifo_re_s   = !rst && (state_r == ST_RUN) && !fifo_empty && (credit_s < 3'd2);
    busy_s      = !rst && ((state_r == ST_RUN) || (state_r == ST_FLUSH));
    done_s      = !rst && (state_r == ST_DONE);
  end

  // Partition ends once nothing releasable remains and no read is in flight.
  always_comb begin
    unheld_left_s = slot_unheld_left(occ_r, head_r, 1'b0, held_r[0], pop_s)
                  | slot_unheld_left(occ_r, head_r, 1'b1, held_r[1], pop_s);
    flush_done_s  = !unheld_left_s && !inflight_r;
  end

  // Next held bits: the captured word is held unless it belongs to RUN, and
  // an accepted start releases everything, including a word captured in the
  // same cycle.
  always_comb begin
    held_s = held_r;
    if (store_s) begin
      held_s[tail_s] = (state_r != ST_RUN);
    end else begin
      held_s[tail_s] = held_r[tail_s];
    end
    if (start_ok_s) begin
      held_s = 2'b00;
    end else begin
      held_s = held_s;
    end
  end

  // Next occupancy: one in per stored capture, one out per pop.
  always_comb begin
    occ_s = occ_r + {1'b0, store_s} - {1'b0, pop_s};
  end

  // Next-state logic of the partition FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (drop_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_done_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Buffer bookkeeping. Reset drops buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= 2'd0;
      head_r     <= 1'b0;
      held_r     <= 2'b00;
      inflight_r <= 1'b0;
    end else begin
      occ_r      <= occ_s;
      head_r     <= head_r ^ pop_s;
      held_r     <= held_s;
      inflight_r <= fifo_re_s;
    end
  end

  // Buffer payload. It has no reset because occupancy decides validity.
  always_ff @(posedge clk) begin
    if (store_s) begin
      buf_r[tail_s] <= fifo_dout;
    end
  end

  // Hand-off counter. It clears on an accepted start, counts pops, and wraps
  // naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_count_r <= 32'd0;
    end else if (start_ok_s) begin
      edge_count_r <= 32'd0;
    end else if (pop_s) begin
      edge_count_r <= edge_count_r + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign fifo_re    = fifo_re_s;
  assign out_valid  = out_valid_s;
  assign out_src    = head_word_s[FIFO_WIDTH-1 -: FIELD_W];
  assign out_dst    = head_word_s[2*FIELD_W-1 -: FIELD_W];
  assign out_weight = head_word_s[FIELD_W-1:0];
  assign busy       = busy_s;
  assign done       = done_s;
  assign edge_count = edge_count_r;

endmodule

// File: tb/tb_edge_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_edge_fifo_reader
//
// Directed bench for edge_fifo_reader. A simple array-backed FIFO model with
// one cycle of read latency feeds the DUT. Edges accepted downstream are
// collected into a queue and compared with hand-built expected words.
// -----------------------------------------------------------------------------
module tb_edge_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready;
  logic        fifo_empty;
  logic        fifo_re;
  logic [95:0] fifo_dout = '0;
  logic        out_valid;
  logic [31:0] out_src;
  logic [31:0] out_dst;
  logic [31:0] out_weight;
  logic        busy;
  logic        done;
  logic [31:0] edge_count;

  always #5 clk = ~clk;

  edge_fifo_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_re    (fifo_re),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .out_dst    (out_dst),
    .out_weight (out_weight),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count)
  );

  int checks   = 0;
  int failures = 0;

  // Upstream FIFO model
  logic [95:0] fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Observation state
  logic [95:0] got_q [$];
  int          cyc_n         = 0;
  int          done_cnt      = 0;
  int          re_empty_viol = 0;
  int          occ_viol      = 0;
  int          cur_run       = 0;
  int          max_run       = 0;
  int          first_re      = -1;
  int          first_ov      = -1;
  int          re_in_stall   = 0;
  int          stall_bad     = 0;
  logic        lat_arm       = 1'b0;
  logic        stall_on      = 1'b0;
  logic [95:0] stall_ref     = '0;

  localparam logic [95:0] SENT = {32'hFFFF_FFFF, 32'd0, 32'd0};

  function automatic logic [95:0] mk(input logic [31:0] s, input logic [31:0] d, input logic [31:0] w);
    return {s, d, w};
  endfunction

  function automatic logic [95:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '1;
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [95:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 96'(done), 96'd1);
  endtask

  // FIFO read port, cycle counter and downstream scoreboard capture
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!rst && out_valid && out_ready) got_q.push_back({out_src, out_dst, out_weight});
    if (fifo_re && (rd_ptr < wr_ptr)) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitors for protocol rules and stall behaviour
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (fifo_re && fifo_empty) re_empty_viol <= re_empty_viol + 1;
    if (dut.occ_r == 2'd3) occ_viol <= occ_viol + 1;
    if (out_valid) begin
      cur_run <= cur_run + 1;
      if (cur_run + 1 > max_run) max_run <= cur_run + 1;
    end else begin
      cur_run <= 0;
    end
    if (lat_arm && fifo_re && first_re < 0) first_re <= cyc_n;
    if (lat_arm && out_valid && first_ov < 0) first_ov <= cyc_n;
    if (stall_on) begin
      if (fifo_re) re_in_stall <= re_in_stall + 1;
      if (({out_src, out_dst, out_weight} !== stall_ref) || (out_valid !== 1'b1)) stall_bad <= stall_bad + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    tick(2);

    // ---- reset state
    check("rst_fifo_re",    96'(fifo_re),    96'd0);
    check("rst_out_valid",  96'(out_valid),  96'd0);
    check("rst_busy",       96'(busy),       96'd0);
    check("rst_done",       96'(done),       96'd0);
    check("rst_edge_count", 96'(edge_count), 96'd0);

    // ---- scenario 1: 3 edges + sentinel
    push(mk(32'd1, 32'd2, 32'd10));
    push(mk(32'd3, 32'd4, 32'd20));
    push(mk(32'd5, 32'd6, 32'd30));
    push(SENT);
    check("rst_re_nonempty", 96'(fifo_re), 96'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("idle_no_re", 96'(fifo_re), 96'd0);
    got_q.delete();
    done_cnt = 0;
    first_re = -1;
    first_ov = -1;
    lat_arm  = 1'b1;
    pulse_start();
    check("s1_busy",      96'(busy),       96'd1);
    check("s1_cnt_clear", 96'(edge_count), 96'd0);
    wait_done("s1_done", 30);
    check("s1_count", 96'(edge_count),   96'd3);
    check("s1_n",     96'(got_q.size()), 96'd3);
    check("s1_e0", got_at(0), mk(32'd1, 32'd2, 32'd10));
    check("s1_e1", got_at(1), mk(32'd3, 32'd4, 32'd20));
    check("s1_e2", got_at(2), mk(32'd5, 32'd6, 32'd30));
    check("s1_latency", 96'(first_ov - first_re), 96'd2);
    tick(2);
    lat_arm = 1'b0;
    check("s1_done_once", 96'(done_cnt), 96'd1);
    check("s1_idle_busy", 96'(busy),     96'd0);

    // ---- scenario 2: 10 back-to-back edges
    for (int i = 0; i < 10; i++) push(mk(32'd100 + 32'(i), 32'd200 + 32'(i), 32'(i) * 32'd7));
    push(SENT);
    got_q.delete();
    cur_run = 0;
    max_run = 0;
    pulse_start();
    wait_done("s2_done", 60);
    check("s2_run",   96'(max_run),      96'd10);
    check("s2_n",     96'(got_q.size()), 96'd10);
    check("s2_count", 96'(edge_count),   96'd10);
    for (int i = 0; i < 10; i++) check("s2_data", got_at(i), mk(32'd100 + 32'(i), 32'd200 + 32'(i), 32'(i) * 32'd7));
    tick(2);

    // ---- scenario 3: 5-cycle downstream stall mid-stream
    for (int i = 0; i < 8; i++) push(mk(32'd300 + 32'(i), 32'd400 + 32'(i), 32'd1000 + 32'(i)));
    push(SENT);
    got_q.delete();
    pulse_start();
    tick(4);
    out_ready   = 1'b0;
    stall_ref   = {out_src, out_dst, out_weight};
    check("s3_valid_at_stall", 96'(out_valid), 96'd1);
    re_in_stall = 0;
    stall_bad   = 0;
    stall_on    = 1'b1;
    tick(5);
    stall_on    = 1'b0;
    out_ready   = 1'b1;
    wait_done("s3_done", 60);
    check("s3_re_le2",  96'(re_in_stall <= 2), 96'd1);
    check("s3_stable",  96'(stall_bad),        96'd0);
    check("s3_n",       96'(got_q.size()),     96'd8);
    check("s3_count",   96'(edge_count),       96'd8);
    for (int i = 0; i < 8; i++) check("s3_data", got_at(i), mk(32'd300 + 32'(i), 32'd400 + 32'(i), 32'd1000 + 32'(i)));
    tick(2);

    // ---- scenario 4: edge read in flight behind the sentinel is retained
    push(mk(32'd11, 32'd12, 32'd13));
    push(mk(32'd21, 32'd22, 32'd23));
    push(SENT);
    push(mk(32'd77, 32'd78, 32'd79));
    got_q.delete();
    pulse_start();
    wait_done("s4_done", 30);
    check("s4_n",     96'(got_q.size()), 96'd2);
    check("s4_e0",    got_at(0), mk(32'd11, 32'd12, 32'd13));
    check("s4_e1",    got_at(1), mk(32'd21, 32'd22, 32'd23));
    check("s4_count", 96'(edge_count), 96'd2);
    tick(3);
    check("s4_idle_no_valid", 96'(out_valid),  96'd0);
    check("s4_count_hold",    96'(edge_count), 96'd2);
    push(mk(32'd88, 32'd89, 32'd90));
    push(SENT);
    got_q.delete();
    pulse_start();
    check("s4_restart_cnt",  96'(edge_count), 96'd0);
    check("s4_held_first_v", 96'(out_valid),  96'd1);
    check("s4_held_first_d", {out_src, out_dst, out_weight}, mk(32'd77, 32'd78, 32'd79));
    wait_done("s4b_done", 30);
    check("s4b_n",     96'(got_q.size()), 96'd2);
    check("s4b_e0",    got_at(0), mk(32'd77, 32'd78, 32'd79));
    check("s4b_e1",    got_at(1), mk(32'd88, 32'd89, 32'd90));
    check("s4b_count", 96'(edge_count), 96'd2);
    tick(2);

    // ---- scenario 5: reset with one entry buffered and one read in flight
    for (int i = 0; i < 6; i++) push(mk(32'd500 + 32'(i), 32'd600 + 32'(i), 32'd700 + 32'(i)));
    out_ready = 1'b0;
    got_q.delete();
    pulse_start();
    tick(2);
    rst = 1'b1;
    check("s5_re_in_rst", 96'(fifo_re), 96'd0);
    tick(1);
    check("s5_valid_after_rst", 96'(out_valid),  96'd0);
    check("s5_count_after_rst", 96'(edge_count), 96'd0);
    check("s5_busy_after_rst",  96'(busy),       96'd0);
    rst = 1'b0;
    tick(2);
    check("s5_no_stale_valid", 96'(out_valid), 96'd0);
    push(SENT);
    out_ready = 1'b1;
    pulse_start();
    wait_done("s5_done", 40);
    check("s5_n",     96'(got_q.size()), 96'd4);
    check("s5_count", 96'(edge_count),   96'd4);
    for (int i = 0; i < 4; i++) check("s5_data", got_at(i), mk(32'd502 + 32'(i), 32'd602 + 32'(i), 32'd702 + 32'(i)));
    tick(2);

    // ---- scenario 6: start ignored in RUN, counter wrap
    for (int i = 0; i < 4; i++) push(mk(32'd900 + 32'(i), 32'd910 + 32'(i), 32'd920 + 32'(i)));
    push(SENT);
    out_ready = 1'b0;
    got_q.delete();
    pulse_start();
    tick(5);
    force dut.edge_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.edge_count_r;
    pulse_start();
    check("s6_start_ignored", 96'(edge_count), 96'h0_FFFF_FFFE);
    check("s6_still_busy",    96'(busy),       96'd1);
    out_ready = 1'b1;
    tick(2);
    check("s6_wrap", 96'(edge_count), 96'd0);
    wait_done("s6_done", 30);
    check("s6_final_count", 96'(edge_count),   96'd2);
    check("s6_n",           96'(got_q.size()), 96'd4);
    for (int i = 0; i < 4; i++) check("s6_data", got_at(i), mk(32'd900 + 32'(i), 32'd910 + 32'(i), 32'd920 + 32'(i)));
    tick(2);

    // ---- global protocol rules
    check("no_re_while_empty", 96'(re_empty_viol), 96'd0);
    check("occ_le_2",          96'(occ_viol),      96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
